// File: rtl/rf_dump_reader_if.sv
// Debug dump bus: regfile read port, start/abort control and the {addr, data} word stream.
// Latency: none, this is wiring only.
// Backpressure: out_valid/out_ready handshake; a word transfers when both are high.
// Ports: master = dump engine side, slave = regfile + debug consumer side.
interface rf_dump_reader_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              done;

    modport master (
        input  start, abort, rd_data, out_ready,
        output rd_addr, busy, out_valid, out_addr, out_data, done
    );

    modport slave (
        output start, abort, rd_data, out_ready,
        input  rd_addr, busy, out_valid, out_addr, out_data, done
    );
endinterface

// File: rtl/rf_dump_reader.sv
// Register file dump engine: walks FIRST_REG..LAST_REG and streams {addr, data} words.
// Latency: first word valid 2 cycles after start is driven, 2 cycles per word with ready tied high.
// Backpressure: word held stable in SEND until out_ready; abort discards it regardless of ready.
// Ports: clk, rst (async active-low), bus (master modport of rf_dump_reader_if).
module rf_dump_reader #(
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    rf_dump_reader_if.master  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                // abort is meaningless here, so start always wins
                if (bus.start) begin
                    state_d = S_READ;
                    cnt_d   = FIRST_A;
                end
            end
            S_READ: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else begin
                    addr_d  = cnt_q;
                    data_d  = bus.rd_data;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // abort outranks a same-cycle handshake: the word is dropped
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.out_ready) begin
                    // compare before incrementing so the counter can never wrap
                    if (cnt_q == LAST_A) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                // DONE always completes its pulse, abort or not
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Counter only moves on start or increment, so rd_addr holds its last value outside READ
    assign bus.rd_addr   = cnt_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = (state_q == S_SEND);
    assign bus.done      = (state_q == S_DONE);
    assign bus.out_addr  = addr_q;
    assign bus.out_data  = data_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
module tb_rf_dump_reader;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;
    int   cnum;

    rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif_a ();
    rf_dump_reader_if #(.ADDR_W(5), .DATA_W(32)) dif_b ();

    logic [31:0] rfa [32];
    logic [31:0] rfb [32];

    assign dif_a.rd_data = (dif_a.rd_addr == 5'd0) ? 32'd0 : rfa[dif_a.rd_addr];
    assign dif_b.rd_data = (dif_b.rd_addr == 5'd0) ? 32'd0 : rfb[dif_b.rd_addr];

    rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(0), .LAST_REG(31)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (dif_a)
    );

    rf_dump_reader #(.ADDR_W(5), .DATA_W(32), .FIRST_REG(7), .LAST_REG(7)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (dif_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state for DUT A: a_idx is the number of words the consumer has taken
    int          a_idx;
    int          a_done_cnt;
    int          a_start_cyc;
    int          a_first_cyc;
    int          a_done_cyc;
    logic        a_pv;
    logic [4:0]  a_hold_addr;
    logic [31:0] a_hold_data;
    logic [31:0] a_first_data;
    logic [31:0] a_last_data;
    logic        a_busy_at_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cnum);
    endtask

    // expected dump value for register i under the preload rule
    function automatic logic [31:0] model_a(input int i);
        return (i == 0) ? 32'd0 : rfa[i];
    endfunction

    task automatic compare_all();
        // a word shown last cycle and accepted at the edge just passed
        if (a_pv && dif_a.out_ready && !dif_a.abort) a_idx++;
        if (dif_a.out_valid) begin
            if (a_first_cyc < 0) begin
                a_first_cyc  = cnum - a_start_cyc;
                a_first_data = dif_a.out_data;
            end
            if (a_idx == 31) a_last_data = dif_a.out_data;
            chk("word_addr", 64'(dif_a.out_addr), 64'(a_idx));
            chk("word_data", 64'(dif_a.out_data), 64'(model_a(a_idx)));
            if (a_pv && !(dif_a.out_ready && !dif_a.abort)) begin
                chk("hold_addr", 64'(dif_a.out_addr), 64'(a_hold_addr));
                chk("hold_data", 64'(dif_a.out_data), 64'(a_hold_data));
            end
            a_hold_addr = dif_a.out_addr;
            a_hold_data = dif_a.out_data;
        end
        if (dif_a.done) begin
            a_done_cnt++;
            a_done_cyc     = cnum - a_start_cyc;
            a_busy_at_done = dif_a.busy;
        end
        a_pv = dif_a.out_valid;
    endtask

    task automatic cyc();
        @(negedge clk);
        cnum++;
        compare_all();
    endtask

    task automatic clear_sb();
        a_idx       = 0;
        a_done_cnt  = 0;
        a_first_cyc = -1;
        a_done_cyc  = -1;
    endtask

    // mode 0: ready high, timing checked; mode 1: ready 1-in-3; mode 2: extra start at word 10
    task automatic dump_a(input int mode);
        bit pulsed;
        pulsed = 0;
        clear_sb();
        dif_a.out_ready = (mode == 1) ? 1'b0 : 1'b1;
        dif_a.start     = 1'b1;
        a_start_cyc     = cnum;
        for (int k = 0; k < 400 && a_done_cnt == 0; k++) begin
            cyc();
            dif_a.start = 1'b0;
            if (mode == 1) dif_a.out_ready = (cnum % 3 == 0);
            if (mode == 2 && !pulsed && dif_a.out_valid && a_idx == 10) begin
                dif_a.start = 1'b1;
                pulsed      = 1;
            end
        end
        chk("dump_words", 64'(a_idx), 64'd32);
        chk("dump_done_pulse", 64'(a_done_cnt), 64'd1);
        chk("busy_in_done", 64'(a_busy_at_done), 64'd1);
        if (mode == 0) begin
            chk("first_valid_lat", 64'(a_first_cyc), 64'd2);
            chk("done_lat", 64'(a_done_cyc), 64'd65);
            chk("first_word_data", 64'(a_first_data), 64'h0);
            chk("last_word_data", 64'(a_last_data), 64'h101F);
        end
        dif_a.out_ready = 1'b1;
        cyc();
        chk("busy_after_done", 64'(dif_a.busy), 64'd0);
        chk("done_after_done", 64'(dif_a.done), 64'd0);
        repeat (3) cyc();
        chk("single_done", 64'(a_done_cnt), 64'd1);
    endtask

    task automatic check_zero_a(input string tag);
        chk({tag, "_rd_addr"},   64'(dif_a.rd_addr),   64'd0);
        chk({tag, "_busy"},      64'(dif_a.busy),      64'd0);
        chk({tag, "_out_valid"}, 64'(dif_a.out_valid), 64'd0);
        chk({tag, "_out_addr"},  64'(dif_a.out_addr),  64'd0);
        chk({tag, "_out_data"},  64'(dif_a.out_data),  64'd0);
        chk({tag, "_done"},      64'(dif_a.done),      64'd0);
    endtask

    task automatic wait_word_a(input int addr);
        int k;
        k = 0;
        while (!(dif_a.out_valid && dif_a.out_addr == 5'(addr)) && k < 200) begin
            cyc();
            dif_a.start = 1'b0;
            k++;
        end
        chk("wait_word_timeout", 64'(k < 200), 64'd1);
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        cnum = 0;
        a_pv = 1'b0;
        a_hold_addr = '0;
        a_hold_data = '0;
        a_first_data = '0;
        a_last_data = '0;
        a_busy_at_done = 1'b0;
        a_start_cyc = 0;
        clear_sb();
        for (int i = 0; i < 32; i++) begin
            rfa[i] = 32'h1000 + 32'(i);
            rfb[i] = 32'h0;
        end
        rfb[7] = 32'hDEADBEEF;
        dif_a.start = 1'b0; dif_a.abort = 1'b0; dif_a.out_ready = 1'b1;
        dif_b.start = 1'b0; dif_b.abort = 1'b0; dif_b.out_ready = 1'b1;

        rst = 1'b1;
        #3 rst = 1'b0;
        #1 check_zero_a("reset");
        repeat (2) cyc();
        rst = 1'b1;
        repeat (2) cyc();

        // full dump, ready tied high
        dump_a(0);
        // backpressure
        dump_a(1);
        // start while busy is ignored
        dump_a(2);

        // abort while word 5 is presented with ready high
        clear_sb();
        dif_a.out_ready = 1'b1;
        dif_a.start = 1'b1;
        a_start_cyc = cnum;
        wait_word_a(5);
        dif_a.abort = 1'b1;
        cyc();
        dif_a.abort = 1'b0;
        chk("abort_valid", 64'(dif_a.out_valid), 64'd0);
        chk("abort_busy", 64'(dif_a.busy), 64'd0);
        chk("abort_done", 64'(dif_a.done), 64'd0);
        chk("abort_words", 64'(a_idx), 64'd5);
        repeat (3) cyc();
        chk("abort_no_done", 64'(a_done_cnt), 64'd0);
        dump_a(0);

        // asynchronous reset in the middle of word 12
        clear_sb();
        dif_a.start = 1'b1;
        a_start_cyc = cnum;
        wait_word_a(12);
        rst = 1'b0;
        a_pv = 1'b0;
        #1 check_zero_a("midreset");
        repeat (2) cyc();
        chk("midreset_no_done", 64'(a_done_cnt), 64'd0);
        rst = 1'b1;
        cyc();
        dump_a(0);

        // single-register dump on the second instance, with a write to r8 during it
        dif_b.start = 1'b1;
        cyc();
        dif_b.start = 1'b0;
        rfb[8] = 32'h12345678;
        chk("b_busy_read", 64'(dif_b.busy), 64'd1);
        chk("b_valid_read", 64'(dif_b.out_valid), 64'd0);
        cyc();
        chk("b_valid", 64'(dif_b.out_valid), 64'd1);
        chk("b_addr", 64'(dif_b.out_addr), 64'd7);
        chk("b_data", 64'(dif_b.out_data), 64'hDEADBEEF);
        cyc();
        chk("b_done", 64'(dif_b.done), 64'd1);
        chk("b_valid_done", 64'(dif_b.out_valid), 64'd0);
        chk("b_busy_done", 64'(dif_b.busy), 64'd1);
        cyc();
        chk("b_busy_after", 64'(dif_b.busy), 64'd0);
        chk("b_done_after", 64'(dif_b.done), 64'd0);
        chk("b_valid_after", 64'(dif_b.out_valid), 64'd0);
        repeat (2) cyc();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/rf_dump_reader.md
Name: rf_dump_reader

Overview:
- Debug read-out engine on the CPU register file's read side.
- On a start pulse, walks register addresses FIRST_REG..LAST_REG through one regfile read port.
- Snapshots each read value and streams {address, data} words to a debug consumer over a valid/ready handshake.
- Sits beside the datapath; it borrows a read port only while busy is high, and top-level muxes raddr on busy.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- FIRST_REG, 0, first address dumped.
- LAST_REG, 31, last address dumped; must be >= FIRST_REG.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a dump; ignored while busy.
- abort  input  1  cancel the dump in progress.
- rd_addr  output  ADDR_W  address driven to the regfile read port.
- rd_data  input  DATA_W  combinational regfile read data for rd_addr; address 0 returns 0.
- busy  output  1  high from the cycle after an accepted start until the cycle after DONE.
- out_valid  output  1  out_addr/out_data hold a valid word.
- out_ready  input  1  consumer accepts the word when valid and ready are both high.
- out_addr  output  ADDR_W  register number of the current word.
- out_data  output  DATA_W  snapshot value of that register.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset: clk single clock; rst asynchronous, active-low. While rst=0, state is IDLE and these outputs are 0: rd_addr, busy, out_valid, out_addr, out_data, done.
- Reset mid-dump returns immediately to IDLE. No done pulse.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE:
  - start=1 → READ; addr counter loads FIRST_REG; busy=1 from next cycle.
  - abort is ignored in IDLE.
- READ (1 cycle):
  - rd_addr = counter; rd_data is sampled at the clock edge into out_data, and counter goes into out_addr.
  - out_valid=1 from the next cycle → SEND.
- SEND:
  - out_valid=1; out_addr/out_data held stable until the handshake.
  - On out_valid & out_ready: if counter==LAST_REG → DONE; else counter+1 → READ.
  - out_valid drops the cycle after the handshake.
- DONE (1 cycle): done=1, out_valid=0 → IDLE.
  - busy is still 1 in DONE and 0 from the next cycle.
  - start in DONE is ignored.
- rd_addr is held at the last driven value outside READ; it is not significant while busy=0.
- Throughput: 2 cycles per register when out_ready is tied high.
  - Full dump of 32 registers: start edge t, first valid at t+2, done at t+65, busy low at t+66.
- Snapshot semantics:
  - Each value reflects the regfile content at its own READ cycle.
  - A write during the dump is visible only for registers not yet read; no coherence across registers.
- Abort:
  - abort=1 in READ or SEND → IDLE next cycle; out_valid, busy and done all 0.
  - The word in flight is discarded even if out_ready was high the same cycle; abort has priority over the handshake.
  - abort in DONE still lets done pulse.
- Counter never wraps: the LAST_REG check precedes any increment.
  - FIRST_REG==LAST_REG gives exactly one word.
- start and abort asserted together in IDLE → start wins.

Test Plan:
- Reset, preload regfile r[i]=0x1000+i (r0 reads 0), out_ready=1, pulse start → 32 words (0,0x0),(1,0x1001)…(31,0x101F); first valid 2 cycles after start; done exactly 65 cycles after start; busy low one cycle later.
- Backpressure: out_ready toggles 1-in-3 during the dump → each word held stable while valid & !ready; sequence and values unchanged; no duplicates or drops.
- Start during busy: second start pulse at word 10 → ignored; still exactly 32 words and one done pulse.
- Abort with out_ready=1 while word 5 is in SEND → word 5 not counted; out_valid=0 and busy=0 next cycle; no done; a new start restarts at address 0.
- Async reset mid-dump: drop rst between clock edges during word 12 → outputs 0 immediately, before the next clock edge; after release a start produces a full 32-word dump.
- Parameter case FIRST_REG=LAST_REG=7, r7=0xDEADBEEF → single word (7,0xDEADBEEF), done 3 cycles after start; a concurrent regfile write to r8 has no effect.
